// File: rtl/la_iocfg_pkg.sv
// Shared types and constants for the GPIO bank
// configuration sequencer.
package la_iocfg_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    EN_WAIT,
    IDLE,
    HOLD,
    APPLY,
    RELEASE
  } state_t;

  localparam int CFG_HLD_N = 0;
  localparam int CFG_EN    = 1;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/la_iocfg_timer.sv
// Loadable down-counter; done while it reads zero.
// Loading N-1 makes the owning state last N cycles.
module la_iocfg_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  // load wins; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/la_iocfg_seq.sv
// Power-up sequencer and glitch-free config owner
// for a bank of bidirectional GPIO pads.
module la_iocfg_seq
  import la_iocfg_pkg::*;
#(
  parameter int NPADS  = 8,
  parameter int CFGW   = 16,
  parameter int AW     = 3,
  parameter int PWRUP  = 16,
  parameter int SETTLE = 4,
  parameter logic [CFGW-1:0] DEFCFG = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic [CFGW-1:0]       req_data,
  output logic [NPADS*CFGW-1:0] cfg,
  output logic                  powered,
  output logic                  busy
);

  localparam int TMAX = imax(PWRUP, SETTLE);
  localparam int TW   = imax(1, $clog2(TMAX));
  localparam int DW   = CFGW - 2;
  localparam logic [AW:0] NP = (AW+1)'(NPADS);

  state_t state, ns;

  logic          tload;
  logic [TW-1:0] tval;
  logic          tdone;

  logic          accept;
  logic          in_range;
  logic [AW-1:0] tgt_n;
  logic          wr_n;

  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;

  logic [CFGW-1:0] pad_q [NPADS];
  logic [CFGW-1:0] pad_n [NPADS];

  logic ready_q, ready_n;
  logic busy_q, busy_n;
  logic powered_q, powered_n;

  logic unused_lsbs;
  assign unused_lsbs = ^req_data[1:0];

  assign accept   = req_valid & ready_q;
  assign in_range = ({1'b0, req_addr} < NP);

  la_iocfg_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .load (rst | tload),
    .value(rst ? TW'(PWRUP - 1) : tval),
    .done (tdone)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PWR_WAIT;
    end else begin
      state <= ns;
    end
  end

  // capture target and data of an accepted write
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      pend_addr <= req_addr;
      pend_data <= req_data[CFGW-1:2];
    end
  end

  // next-state and timer reload
  always_comb begin
    ns    = state;
    tload = 1'b0;
    tval  = TW'(SETTLE - 1);
    unique case (state)
      PWR_WAIT: begin
        if (tdone) begin
          ns    = EN_WAIT;
          tload = 1'b1;
        end
      end
      EN_WAIT: begin
        if (tdone) ns = IDLE;
      end
      IDLE: begin
        if (accept && in_range) begin
          ns    = HOLD;
          tload = 1'b1;
        end
      end
      HOLD: begin
        if (tdone) ns = APPLY;
      end
      APPLY: begin
        ns    = RELEASE;
        tload = 1'b1;
      end
      RELEASE: begin
        if (tdone) ns = IDLE;
      end
      default: ns = state;
    endcase
  end

  // next register contents, derived from the upcoming state
  always_comb begin
    tgt_n = (accept && in_range) ? req_addr : pend_addr;
    wr_n  = (ns == HOLD) || (ns == APPLY)
         || (ns == RELEASE);
    for (int k = 0; k < NPADS; k++) begin
      pad_n[k] = pad_q[k];
      if (state == APPLY && pend_addr == AW'(k)) begin
        pad_n[k][CFGW-1:2] = pend_data;
      end
      pad_n[k][CFG_EN]    = (ns != PWR_WAIT);
      pad_n[k][CFG_HLD_N] = (ns == IDLE)
                         || (wr_n && tgt_n != AW'(k));
    end
    ready_n   = (ns == IDLE);
    busy_n    = wr_n;
    powered_n = powered_q | (ns == IDLE);
  end

  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NPADS; k++) begin
        pad_q[k] <= {DEFCFG[CFGW-1:2], 2'b00};
      end
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      powered_q <= 1'b0;
    end else begin
      for (int k = 0; k < NPADS; k++) begin
        pad_q[k] <= pad_n[k];
      end
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      powered_q <= powered_n;
    end
  end

  // flatten pad registers onto the ring bus
  always_comb begin
    for (int k = 0; k < NPADS; k++) begin
      cfg[k*CFGW +: CFGW] = pad_q[k];
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign powered   = powered_q;

endmodule

// File: tb/tb_la_iocfg_seq.sv
// Bench for la_iocfg_seq: timeline model of the
// power-up and write sequences plus pinned literals.
module tb_la_iocfg_seq;

  localparam int NPADS  = 4;
  localparam int CFGW   = 16;
  localparam int AW     = 3;
  localparam int PWRUP  = 8;
  localparam int SETTLE = 3;
  localparam logic [15:0] DEF = 16'h0000;
  localparam int WLEN = 2*SETTLE + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [CFGW-1:0] req_data = '0;
  logic req_ready, powered, busy;
  logic [NPADS*CFGW-1:0] cfg;

  always #5 clk = ~clk;

  la_iocfg_seq #(
    .NPADS (NPADS),
    .CFGW  (CFGW),
    .AW    (AW),
    .PWRUP (PWRUP),
    .SETTLE(SETTLE),
    .DEFCFG(DEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .cfg      (cfg),
    .powered  (powered),
    .busy     (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // model: t = cycles since the last reset edge,
  // age = cycles since a write was accepted (1 = first)
  int t = 0;
  int age = 0;
  int acc_n = 0;
  int acc_cyc = 0;
  int cyc = 0;
  bit act = 0;
  bit mvalid = 0;
  logic [AW-1:0] tgt;
  logic [15:0] wdat;
  logic [15:0] mcfg [NPADS];

  always @(posedge clk) begin
    bit rdy_b;
    cyc++;
    if (rst) begin
      t = 0;
      act = 0;
      age = 0;
      for (int k = 0; k < NPADS; k++) mcfg[k] = DEF;
      mvalid = 1;
    end else if (mvalid) begin
      rdy_b = (t >= PWRUP + SETTLE) && !act;
      if (act) begin
        age++;
        if (age > WLEN) begin
          mcfg[tgt] = wdat;
          act = 0;
        end
      end
      if (t < 1000000) t++;
      if (rdy_b && req_valid) begin
        acc_n++;
        acc_cyc = cyc;
        if (int'(req_addr) < NPADS) begin
          act = 1;
          age = 1;
          tgt = req_addr;
          wdat = req_data;
        end
      end
    end
  end

  function automatic logic [63:0] exp_cfg();
    logic [63:0] r;
    logic [15:0] d;
    bit mine;
    r = '0;
    for (int k = 0; k < NPADS; k++) begin
      mine = act && (int'(tgt) == k);
      d = (mine && age >= SETTLE + 2) ? wdat : mcfg[k];
      r[k*16 +: 16] = {d[15:2], 1'(t >= PWRUP),
        1'((t >= PWRUP + SETTLE) && !mine)};
    end
    return r;
  endfunction

  logic [63:0] prev_cfg;
  bit have_prev = 0;

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (mvalid) begin
      chk("cfg", cfg, exp_cfg());
      chk("req_ready", req_ready,
          (t >= PWRUP + SETTLE) && !act);
      chk("busy", busy, act);
      chk("powered", powered, t >= PWRUP + SETTLE);
      if (have_prev) begin
        for (int k = 0; k < NPADS; k++) begin
          chk("glitch", cfg[k*16] &&
              (cfg[k*16+2 +: 14] != prev_cfg[k*16+2 +: 14]),
              1'b0);
        end
      end
      prev_cfg = cfg;
      have_prev = 1;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int a, logic [15:0] d, bit hold);
    int n0;
    bit ok;
    req_valid = 1'b1;
    req_addr = AW'(a);
    req_data = d;
    n0 = acc_n;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_n != n0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    int a0;
    logic [63:0] snap;
    tick(2);
    rst = 1'b0;
    chk("rst_cfg", cfg, 64'h0);
    chk("rst_ready", req_ready, 1'b0);
    tick(PWRUP - 1);
    chk("pwr_last", cfg, 64'h0);
    tick(1);
    chk("en_first", cfg, 64'h0002_0002_0002_0002);
    tick(SETTLE - 1);
    chk("en_powered", powered, 1'b0);
    tick(1);
    chk("idle_cfg", cfg, 64'h0003_0003_0003_0003);
    chk("idle_powered", powered, 1'b1);
    chk("idle_ready", req_ready, 1'b1);

    wr(2, 16'hA5FF, 0);
    chk("p2_hold", cfg[47:32], 16'h0002);
    tick(SETTLE);
    chk("p2_apply", cfg[47:32], 16'h0002);
    tick(1);
    chk("p2_release", cfg[47:32], 16'hA5FE);
    tick(SETTLE);
    chk("p2_idle", cfg, 64'h0003_A5FF_0003_0003);

    snap = cfg;
    wr(5, 16'hFFFF, 0);
    chk("oor_ready", req_ready, 1'b1);
    chk("oor_busy", busy, 1'b0);
    chk("oor_cfg", cfg, snap);

    wr(0, 16'h1234, 1);
    a0 = acc_cyc;
    wr(3, 16'h8000, 0);
    chk("b2b_gap", acc_cyc - a0, WLEN + 1);
    tick(WLEN);
    chk("b2b_cfg", cfg, 64'h8003_A5FF_0003_1237);

    wr(1, 16'hBEEF, 0);
    tick(2*SETTLE - 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_cfg", cfg, 64'h0);
    chk("mid_rst_pwr", powered, 1'b0);
    chk("mid_rst_rdy", req_ready, 1'b0);
    tick(PWRUP + SETTLE);
    chk("repwr_cfg", cfg, 64'h0003_0003_0003_0003);

    for (int i = 0; i < 200; i++) begin
      int g;
      g = $urandom_range(0, 2);
      wr($urandom_range(0, 7), 16'($urandom), g == 0);
      tick(g);
    end
    req_valid = 1'b0;
    tick(WLEN + 3);
    chk("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
